multi_core_search_ctrl: RTL and testbench
=========================================

Name: multi_core_search_ctrl

Overview:
- Parametrised master controller for the RC4 key-search datapath.
- Launches NUM_CORES cracking cores together, each searching its own key subrange, then monitors per-core success and exhaustion flags.
- On the first match it latches the winning core index and key and broadcasts stop. If every core exhausts its range with no match, it reports not-found.
- Supports restart without reset, so the top level can rerun a search with a new ciphertext.

Parameters:
- NUM_CORES, 4, number of cracking cores monitored (1..16).
- KEY_WIDTH, 24, width of each core's candidate key in bits.
- IDX_WIDTH, $clog2(NUM_CORES) (minimum 1), width of winner_idx. Derived; not overridden.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle request to begin or restart a search.
- core_success  input  NUM_CORES  bit i high: core i's current key decrypts to valid plaintext.
- core_done  input  NUM_CORES  bit i high: core i has exhausted its subrange (may be a pulse or a level).
- core_key  input  NUM_CORES*KEY_WIDTH  flattened candidate keys; core i occupies bits [i*KEY_WIDTH +: KEY_WIDTH].
- core_start  output  NUM_CORES  one-cycle launch pulse to every core.
- stop  output  1  broadcast halt to all cores.
- busy  output  1  high while a search is in flight.
- found  output  1  search ended with a match.
- not_found  output  1  search ended with all ranges exhausted.
- winner_idx  output  IDX_WIDTH  index of the matching core.
- winner_key  output  KEY_WIDTH  key reported by the matching core.

Behaviour:
- States: IDLE, LAUNCH, RUN, FOUND, EXHAUSTED.
- Reset (asynchronous, reset=0):
  - state goes to IDLE.
  - done_mask, winner_idx, winner_key, core_start, stop, busy, found and not_found all go to 0.
  - This applies at any time, including mid-RUN.
- IDLE:
  - start=1 moves to LAUNCH.
  - core_success and core_done are ignored.
- LAUNCH (exactly one cycle):
  - clears done_mask.
  - unconditionally moves to RUN.
- RUN:
  - done_mask |= core_done every cycle; bits are sticky.
  - If any core_success bit is set: move to FOUND. winner_idx is the lowest set bit of core_success; winner_key is that core's core_key slice. Both are captured on the same edge.
  - Else if (done_mask | core_done) is all ones: move to EXHAUSTED.
  - Success beats exhaustion when both happen in the same cycle.
- FOUND / EXHAUSTED:
  - Terminal and held.
  - Later core_success and core_done activity is ignored; winner registers are frozen.
  - start=1 moves to LAUNCH (restart). winner_idx and winner_key keep their old values until the next capture.
- start is ignored in LAUNCH and RUN.
- All outputs are registered from the state, so each lags the state by one cycle:
  - core_start = all ones in the cycle after state is LAUNCH.
  - busy = 1 while state is LAUNCH or RUN, one cycle late.
  - stop = 1 while state is FOUND or EXHAUSTED, one cycle late.
  - found is the same as stop but for FOUND only; not_found is the same but for EXHAUSTED only.
- Latency:
  - start sampled on edge k gives core_start high in cycle k+2, for one cycle.
  - core_success sampled on edge m gives stop and found high from cycle m+2. winner_idx and winner_key are already valid from cycle m+1.
- Exactly one of {busy, found, not_found} is high outside IDLE, once the one-cycle output lag has settled.
- The NUM_CORES=1 build must work: IDX_WIDTH=1, winner_idx always 0.
- Illegal state encodings recover to IDLE.

Test Plan (NUM_CORES=4, KEY_WIDTH=24 unless noted):
- Reset, then start pulse: core_start=4'b1111 for exactly one cycle, two cycles after the start edge; busy=1; stop=0.
- In RUN, core_success=4'b0100 with core 2 key 24'h03A1F0: winner_idx=2 and winner_key=24'h03A1F0 one cycle later; stop=1, found=1 the cycle after; both hold for 20+ cycles under input toggling.
- Simultaneous core_success=4'b1010: winner_idx=1, core 1's key latched.
- core_done pulses 0001, 0100, 1000, then 0010 on separate cycles with no success: not_found=1 and stop=1 two cycles after the last pulse; found=0.
- Same cycle core_done completes the mask and core_success=4'b0001: FOUND with winner_idx=0; not_found never asserts.
- reset=0 mid-RUN asynchronously zeroes stop, busy and core_start; a start pulse while in FOUND relaunches, clearing stop and found, then a new capture updates winner_key.

Source files
------------

// File: rtl/multi_core_search_ctrl.sv
// Master controller for the RC4 key-search datapath: launch all cores, watch success/exhaustion, latch winner.
// start edge k -> core_start in cycle k+2; core_success edge m -> winner valid m+1, stop/found from m+2.
// No backpressure: start is only honoured in IDLE/FOUND/EXHAUSTED, ignored while a search is in flight.
module multi_core_search_ctrl #(
   parameter  int NUM_CORES = 4,
   parameter  int KEY_WIDTH = 24,
   localparam int IDX_WIDTH = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic [NUM_CORES-1:0]           core_success,
   input  logic [NUM_CORES-1:0]           core_done,
   input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
   output logic [NUM_CORES-1:0]           core_start,
   output logic                           stop,
   output logic                           busy,
   output logic                           found,
   output logic                           not_found,
   output logic [IDX_WIDTH-1:0]           winner_idx,
   output logic [KEY_WIDTH-1:0]           winner_key
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LAUNCH    = 3'd1,
      RUN       = 3'd2,
      FOUND     = 3'd3,
      EXHAUSTED = 3'd4
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic                   capture;
   logic [NUM_CORES-1:0]   done_mask;
   logic                   hit_any;
   logic [IDX_WIDTH-1:0]   hit_idx;
   logic [KEY_WIDTH-1:0]   hit_key;
   logic                   all_done;

   // Priority pick of the lowest-numbered successful core and its key slice
   always_comb begin
      hit_any = 1'b0;
      hit_idx = '0;
      hit_key = '0;
      for (int i = NUM_CORES - 1; i >= 0; i--) begin
         if (core_success[i]) begin
            hit_any = 1'b1;
            hit_idx = IDX_WIDTH'(i);
            hit_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
         end
      end
   end

   // Include this cycle's done flags so a final pulse completes the mask immediately
   assign all_done = &(done_mask | core_done);

   // Next-state logic; success has priority over exhaustion in the same cycle
   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = LAUNCH;
         end
         LAUNCH: begin
            state_nxt = RUN;
         end
         RUN: begin
            if (hit_any) begin
               state_nxt = FOUND;
               capture   = 1'b1;
            end else if (all_done) begin
               state_nxt = EXHAUSTED;
            end
         end
         FOUND, EXHAUSTED: begin
            if (start) state_nxt = LAUNCH;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Sticky per-core exhaustion mask, cleared on every launch
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)               done_mask <= '0;
      else if (state == LAUNCH) done_mask <= '0;
      else if (state == RUN)    done_mask <= done_mask | core_done;
   end

   // Winner registers load only on the RUN->FOUND edge and are otherwise frozen
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         winner_idx <= '0;
         winner_key <= '0;
      end else if (capture) begin
         winner_idx <= hit_idx;
         winner_key <= hit_key;
      end
   end

   // Status outputs are decoded from the current state and registered, lagging it by one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         core_start <= '0;
         busy       <= 1'b0;
         stop       <= 1'b0;
         found      <= 1'b0;
         not_found  <= 1'b0;
      end else begin
         core_start <= (state == LAUNCH) ? '1 : '0;
         busy       <= (state == LAUNCH) || (state == RUN);
         stop       <= (state == FOUND) || (state == EXHAUSTED);
         found      <= (state == FOUND);
         not_found  <= (state == EXHAUSTED);
      end
   end

endmodule

// File: tb/tb_multi_core_search_ctrl.sv
// Scoreboard bench for multi_core_search_ctrl (NUM_CORES=4, KEY_WIDTH=24).
// Stimulus pushes expected launch/termination events; a negedge monitor pops and compares them.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_multi_core_search_ctrl;

   localparam int NC = 4;
   localparam int KW = 24;

   logic            clk;
   logic            reset;
   logic            start;
   logic [NC-1:0]   core_success;
   logic [NC-1:0]   core_done;
   logic [NC*KW-1:0] core_key;
   logic [NC-1:0]   core_start;
   logic            stop;
   logic            busy;
   logic            found;
   logic            not_found;
   logic [1:0]      winner_idx;
   logic [KW-1:0]   winner_key;

   logic [KW-1:0]   k [NC];

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   typedef struct {
      int          is_stop;
      int          cyc;
      logic        fnd;
      logic        nf;
      logic [1:0]  idx;
      logic [KW-1:0] key;
   } exp_t;

   exp_t exp_q[$];

   multi_core_search_ctrl #(.NUM_CORES(NC), .KEY_WIDTH(KW)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .core_success (core_success),
      .core_done    (core_done),
      .core_key     (core_key),
      .core_start   (core_start),
      .stop         (stop),
      .busy         (busy),
      .found        (found),
      .not_found    (not_found),
      .winner_idx   (winner_idx),
      .winner_key   (winner_key)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb core_key = {k[3], k[2], k[1], k[0]};

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic push_start();
      exp_t e;
      e.is_stop = 0; e.cyc = cyc + 2; e.fnd = 1'b0; e.nf = 1'b0; e.idx = '0; e.key = '0;
      exp_q.push_back(e);
   endtask

   task automatic push_stop(input logic fnd, input logic nf, input logic [1:0] idx, input logic [KW-1:0] key);
      exp_t e;
      e.is_stop = 1; e.cyc = cyc + 2; e.fnd = fnd; e.nf = nf; e.idx = idx; e.key = key;
      exp_q.push_back(e);
   endtask

   // Pulse start for one cycle; returns on the falling edge where the DUT sits in LAUNCH
   task automatic do_start();
      tick();
      start = 1'b1;
      push_start();
      tick();
      start = 1'b0;
   endtask

   // Monitor: pop and compare on every launch pulse and every rising stop
   logic prev_cs_any = 1'b0;
   logic prev_stop   = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if ((core_start != '0) && !prev_cs_any) begin
         if (exp_q.size() == 0 || exp_q[0].is_stop != 0) begin
            check("unexpected_core_start", 64'(core_start), 64'h0);
         end else begin
            e = exp_q.pop_front();
            check("core_start_cycle", 64'(cyc), 64'(e.cyc));
            check("core_start_value", 64'(core_start), 64'hF);
            check("launch_busy", 64'(busy), 64'h1);
            check("launch_stop", 64'(stop), 64'h0);
         end
      end
      if (prev_cs_any) check("core_start_one_cycle", 64'(core_start), 64'h0);
      if (stop && !prev_stop) begin
         if (exp_q.size() == 0 || exp_q[0].is_stop != 1) begin
            check("unexpected_stop", 64'(stop), 64'h0);
         end else begin
            e = exp_q.pop_front();
            check("stop_cycle", 64'(cyc), 64'(e.cyc));
            check("end_found", 64'(found), 64'(e.fnd));
            check("end_not_found", 64'(not_found), 64'(e.nf));
            check("end_busy", 64'(busy), 64'h0);
            check("end_winner_idx", 64'(winner_idx), 64'(e.idx));
            check("end_winner_key", 64'(winner_key), 64'(e.key));
         end
      end
      if (reset) check("status_onehot", 64'(32'(busy) + 32'(found) + 32'(not_found) > 1), 64'h0);
      prev_cs_any = (core_start != '0);
      prev_stop   = stop;
   end

   initial begin
      reset = 1'b0; start = 1'b0; core_success = '0; core_done = '0;
      for (int i = 0; i < NC; i++) k[i] = KW'(24'h100000 * (i + 1) + i);

      // Reset state
      repeat (3) tick();
      check("rst_state", {core_start, stop, busy, found, not_found, winner_idx, winner_key},
            64'h0);
      reset = 1'b1;
      repeat (2) tick();

      // Launch, then single success on core 2
      do_start();
      tick();
      check("run_busy", 64'(busy), 64'h1);
      check("run_stop", 64'(stop), 64'h0);
      k[2] = 24'h03A1F0;
      core_success = 4'b0100;
      push_stop(1'b1, 1'b0, 2'd2, 24'h03A1F0);
      tick();
      core_success = '0;
      check("win_idx_early", 64'(winner_idx), 64'd2);
      check("win_key_early", 64'(winner_key), 64'h03A1F0);
      check("stop_not_yet", 64'(stop), 64'h0);
      tick();
      // Hold under input toggling
      for (int i = 0; i < 22; i++) begin
         core_success = NC'($urandom);
         core_done    = NC'($urandom);
         k[i % NC]    = KW'($urandom);
         tick();
         check("hold_found", {stop, found, not_found, winner_idx, winner_key},
               {1'b1, 1'b1, 1'b0, 2'd2, 24'h03A1F0});
      end
      core_success = '0; core_done = '0;

      // Restart from FOUND; simultaneous success picks the lowest core
      do_start();
      tick();
      check("restart_clear", {stop, found, busy}, {1'b0, 1'b0, 1'b1});
      k[1] = 24'h5A5A5A; k[3] = 24'hFFFFFF;
      core_success = 4'b1010;
      push_stop(1'b1, 1'b0, 2'd1, 24'h5A5A5A);
      tick();
      core_success = '0;
      repeat (3) tick();

      // Exhaustion via separate done pulses; winner stays frozen
      do_start();
      tick();
      core_done = 4'b0001; tick();
      core_done = 4'b0000; tick();
      core_done = 4'b0100; tick();
      core_done = 4'b1000; tick();
      core_done = 4'b0000; tick();
      check("no_early_exhaust", {stop, busy}, {1'b0, 1'b1});
      core_done = 4'b0010;
      push_stop(1'b0, 1'b1, 2'd1, 24'h5A5A5A);
      tick();
      core_done = '0;
      repeat (4) tick();
      check("exhaust_held", {stop, found, not_found}, {1'b1, 1'b0, 1'b1});

      // Success and mask completion in the same cycle: success wins
      do_start();
      tick();
      core_done = 4'b0111; tick();
      core_done = 4'b1000;
      k[0] = 24'h00BEEF;
      core_success = 4'b0001;
      push_stop(1'b1, 1'b0, 2'd0, 24'h00BEEF);
      tick();
      core_done = '0; core_success = '0;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("nf_never", 64'(not_found), 64'h0);
      end

      // Asynchronous reset mid-RUN while core_start/busy are high
      do_start();
      tick();
      #2 reset = 1'b0;
      #1 check("async_rst", {core_start, stop, busy, found, winner_key}, 64'h0);
      tick();
      #2 reset = 1'b1;

      // Fresh search after reset
      do_start();
      tick();
      k[1] = 24'h123456;
      core_success = 4'b0010;
      push_stop(1'b1, 1'b0, 2'd1, 24'h123456);
      tick();
      core_success = '0;
      repeat (4) tick();

      check("scoreboard_drained", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
